// File: rtl/timer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_scheduler_pkg
//  Purpose  : Shared arbiter state encodings and sizing helper for the
//             timer scheduler and its round-robin picker.
//  Contents : ARB_IDLE_S / ARB_WAIT_S state codes, N_REQ_MAX, idx_width().
//  Revision : 1.0 - initial release
// ============================================================================
package timer_scheduler_pkg;

   // Arbiter states (2-bit encoding; codes 2 and 3 are illegal)
   localparam logic [1:0] ARB_IDLE_S = 2'd0;
   localparam logic [1:0] ARB_WAIT_S = 2'd1;

   localparam int unsigned N_REQ_MAX = 8;

   // Width of an index into an n-entry vector, never less than 1 bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : timer_scheduler_pkg
`default_nettype wire

// File: rtl/timer_scheduler_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : timer_scheduler_rr_picker
//  Purpose  : Combinational round-robin selector. Scans pend starting at
//             last+1 and wrapping modulo N_REQ, returning the first set bit.
//  Ports    : pend_i  [N_REQ] pending request bits
//             last_i  [IW]    index of the most recent owner (lowest priority)
//             pick_o  [N_REQ] one-hot selected requester (0 if none)
//             idx_o   [IW]    binary index of pick_o
//             valid_o [1]     any request pending
//  Revision : 1.0 - initial release
// ============================================================================
module timer_scheduler_rr_picker
   import timer_scheduler_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] pend_i,
   input  logic [IW-1:0]    last_i,
   output logic [N_REQ-1:0] pick_o,
   output logic [IW-1:0]    idx_o,
   output logic             valid_o
);

   logic          found;
   int unsigned   pos;
   logic [IW-1:0] pos_idx;

   assign valid_o = |pend_i;

   // k runs 1..N_REQ so the previous owner (offset N_REQ) is examined last
   always_comb begin
      pick_o  = '0;
      idx_o   = '0;
      found   = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         pos = 32'(last_i) + k;
         if (pos >= N_REQ) begin
            pos = pos - N_REQ;
         end
         pos_idx = pos[IW-1:0];
         if (!found && pend_i[pos_idx]) begin
            found           = 1'b1;
            pick_o[pos_idx] = 1'b1;
            idx_o           = pos_idx;
         end
      end
   end

endmodule : timer_scheduler_rr_picker
`default_nettype wire

// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : timer_scheduler
//  Purpose  : Shares one external timer between N_REQ requesters with
//             round-robin arbitration, per-requester cancel and a watchdog.
//  Ports    : clk_i        system clock
//             rst_n_i      asynchronous active-low reset
//             clr_i        synchronous clear of all state (pulses tmr_clr_o)
//             req_i        [N_REQ] request bits, set pending while high
//             cancel_i     [N_REQ] clear pending; aborts timer if owner
//             grant_o      [N_REQ] one-hot current owner, 0 when idle
//             done_o       [N_REQ] 1-cycle pulse when owner's timer expires
//             err_o        1-cycle pulse on watchdog abort
//             busy_o       high whenever not idle
//             tmr_start_o  1-cycle start pulse to the timer
//             tmr_clr_o    1-cycle clear pulse to the timer
//             tmr_pulse_i  expiry pulse from the timer
//  Revision : 1.0 - initial release
// ============================================================================
module timer_scheduler
   import timer_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter logic [20:0] WDOG_MAX = 21'h00_0010
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clr_i,
   input  logic [N_REQ-1:0] req_i,
   input  logic [N_REQ-1:0] cancel_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [N_REQ-1:0] done_o,
   output logic             err_o,
   output logic             busy_o,
   output logic             tmr_start_o,
   output logic             tmr_clr_o,
   input  logic             tmr_pulse_i
);

   localparam int unsigned   IW       = idx_width(N_REQ);
   localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

   logic [1:0]       state_q, state_d;
   logic [N_REQ-1:0] pend_q, pend_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             tmr_start_q, tmr_start_d;
   logic             tmr_clr_q, tmr_clr_d;
   logic [IW-1:0]    last_q, last_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [20:0]      wdog_q, wdog_d;

   logic [N_REQ-1:0] pick_w;
   logic [IW-1:0]    pick_idx_w;
   logic             pick_valid_w;
   logic [N_REQ-1:0] own_clr_w;     // owner's pend bit retired by DONE/abort

   timer_scheduler_rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .pend_i  (pend_q),
      .last_i  (last_q),
      .pick_o  (pick_w),
      .idx_o   (pick_idx_w),
      .valid_o (pick_valid_w)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      done_d      = '0;
      err_d       = 1'b0;
      tmr_start_d = 1'b0;
      tmr_clr_d   = 1'b0;
      last_d      = last_q;
      owner_d     = owner_q;
      wdog_d      = wdog_q;
      own_clr_w   = '0;

      if (clr_i) begin
         state_d   = ARB_IDLE_S;
         grant_d   = '0;
         last_d    = LAST_RST;
         owner_d   = '0;
         wdog_d    = '0;
         tmr_clr_d = 1'b1;
      end else begin
         case (state_q)
            ARB_IDLE_S: begin
               if (pick_valid_w) begin
                  grant_d     = pick_w;
                  owner_d     = pick_idx_w;
                  tmr_start_d = 1'b1;
                  wdog_d      = '0;
                  state_d     = ARB_WAIT_S;
               end
            end
            ARB_WAIT_S: begin
               wdog_d = wdog_q + 21'd1;
               // Expiry wins over a simultaneous cancel: the work is done,
               // so the timer needs no clear.
               if (tmr_pulse_i) begin
                  done_d    = grant_q;
                  own_clr_w = grant_q;
                  last_d    = owner_q;
                  grant_d   = '0;
                  state_d   = ARB_IDLE_S;
               end else if (|(cancel_i & grant_q)) begin
                  tmr_clr_d = 1'b1;
                  last_d    = owner_q;
                  grant_d   = '0;
                  state_d   = ARB_IDLE_S;
               end else if (wdog_q == WDOG_MAX) begin
                  err_d     = 1'b1;
                  tmr_clr_d = 1'b1;
                  own_clr_w = grant_q;
                  last_d    = owner_q;
                  grant_d   = '0;
                  state_d   = ARB_IDLE_S;
               end
            end
            default: begin
               state_d = ARB_IDLE_S;
               grant_d = '0;
            end
         endcase
      end

      // New REQ re-arms a bit retired this cycle; CANCEL overrides both
      if (clr_i) begin
         pend_d = '0;
      end else begin
         pend_d = ((pend_q & ~own_clr_w) | req_i) & ~cancel_i;
      end

      busy_d = (state_d != ARB_IDLE_S);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ARB_IDLE_S;
         pend_q      <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         tmr_start_q <= 1'b0;
         tmr_clr_q   <= 1'b0;
         last_q      <= LAST_RST;
         owner_q     <= '0;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         tmr_start_q <= tmr_start_d;
         tmr_clr_q   <= tmr_clr_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         wdog_q      <= wdog_d;
      end
   end

   assign grant_o     = grant_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign busy_o      = busy_q;
   assign tmr_start_o = tmr_start_q;
   assign tmr_clr_o   = tmr_clr_q;

endmodule : timer_scheduler
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_scheduler
//  Purpose  : Directed self-checking bench for timer_scheduler with a small
//             behavioural timer (start-to-pulse period of 5 cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] cancel = '0;
   logic [3:0] grant, done;
   logic       err, busy, tmr_start, tmr_clr, tmr_pulse;

   logic       tmr_en = 1'b1;
   logic       pulse_inj = 1'b0;
   logic       tm_pulse, tm_run;
   logic [2:0] tm_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   timer_scheduler #(
      .N_REQ    (4),
      .WDOG_MAX (21'd16)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .clr_i       (clr),
      .req_i       (req),
      .cancel_i    (cancel),
      .grant_o     (grant),
      .done_o      (done),
      .err_o       (err),
      .busy_o      (busy),
      .tmr_start_o (tmr_start),
      .tmr_clr_o   (tmr_clr),
      .tmr_pulse_i (tmr_pulse)
   );

   // Timer stand-in: start seen at edge s+1, pulse sampled by DUT at s+5
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tm_run   <= 1'b0;
         tm_cnt   <= '0;
         tm_pulse <= 1'b0;
      end else begin
         tm_pulse <= 1'b0;
         if (tmr_clr) begin
            tm_run <= 1'b0;
         end else if (tmr_start) begin
            tm_run <= 1'b1;
            tm_cnt <= '0;
         end else if (tm_run) begin
            if (tm_cnt == 3'd2) begin
               tm_pulse <= 1'b1;
               tm_run   <= 1'b0;
            end else begin
               tm_cnt <= tm_cnt + 3'd1;
            end
         end
      end
   end

   assign tmr_pulse = (tm_pulse & tmr_en) | pulse_inj;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req       = '0;
      cancel    = '0;
      clr       = 1'b0;
      pulse_inj = 1'b0;
      tmr_en    = 1'b1;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b want 0000", grant); end
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL rst_done: got %b want 0000", done); end
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (tmr_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", tmr_start); end
      n_cmp++; if (tmr_clr !== 1'b0) begin n_err++; $display("FAIL rst_tclr: got %b want 0", tmr_clr); end
      n_cmp++; if (dut.pend_q !== 4'b0000) begin n_err++; $display("FAIL rst_pend: got %b want 0000", dut.pend_q); end
      n_cmp++; if (dut.last_q !== 2'd3) begin n_err++; $display("FAIL rst_last: got %0d want 3", dut.last_q); end
   endtask

   task automatic test_single();
      apply_reset();
      req = 4'b0010;
      tick();                                   // E1: pending
      req = 4'b0000;
      n_cmp++; if (dut.pend_q !== 4'b0010) begin n_err++; $display("FAIL t1_pend: got %b want 0010", dut.pend_q); end
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t1_early_grant: got %b want 0000", grant); end
      tick();                                   // E2: grant + start
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t1_grant: got %b want 0010", grant); end
      n_cmp++; if (tmr_start !== 1'b1) begin n_err++; $display("FAIL t1_start: got %b want 1", tmr_start); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want 1", busy); end
      tick();                                   // E3
      n_cmp++; if (tmr_start !== 1'b0) begin n_err++; $display("FAIL t1_start_pulse: got %b want 0", tmr_start); end
      tick(); tick(); tick();                   // E6
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL t1_done_early: got %b want 0000", done); end
      tick();                                   // E7: DONE
      n_cmp++; if (done !== 4'b0010) begin n_err++; $display("FAIL t1_done: got %b want 0010", done); end
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t1_grant_rel: got %b want 0000", grant); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_busy_end: got %b want 0", busy); end
      tick();
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL t1_done_pulse: got %b want 0000", done); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_seq [4];
      int nd;
      int extra;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      nd    = 0;
      extra = 0;
      apply_reset();
      req = 4'b1111;
      tick();
      req = 4'b0000;
      for (int c = 0; c < 60 && nd < 4; c++) begin
         tick();
         if (done !== 4'b0000) begin
            n_cmp++;
            if (done !== exp_seq[nd]) begin
               n_err++;
               $display("FAIL t2_order%0d: got %b want %b", nd, done, exp_seq[nd]);
            end
            nd++;
         end
      end
      n_cmp++; if (nd != 4) begin n_err++; $display("FAIL t2_count: got %0d want 4", nd); end
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done !== 4'b0000) extra++;
      end
      n_cmp++; if (extra != 0) begin n_err++; $display("FAIL t2_extra_done: got %0d want 0", extra); end
      n_cmp++; if (dut.pend_q !== 4'b0000) begin n_err++; $display("FAIL t2_pend: got %b want 0000", dut.pend_q); end
   endtask

   task automatic test_cancel();
      int d1;
      logic [3:0] first_done;
      d1 = 0;
      first_done = 4'b0000;
      apply_reset();
      req = 4'b0110;
      tick();
      req = 4'b0000;
      tick();                                   // E2: owner 1
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t3_grant1: got %b want 0010", grant); end
      tick(); tick();                           // E4
      cancel = 4'b0010;
      tick();                                   // E5: abort
      cancel = 4'b0000;
      n_cmp++; if (tmr_clr !== 1'b1) begin n_err++; $display("FAIL t3_tclr: got %b want 1", tmr_clr); end
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL t3_nodone: got %b want 0000", done); end
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t3_grant_rel: got %b want 0000", grant); end
      tick();                                   // E6: owner 2
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t3_grant2: got %b want 0100", grant); end
      for (int c = 0; c < 20 && first_done == 4'b0000; c++) begin
         tick();
         if (done[1] === 1'b1) d1++;
         if (done !== 4'b0000) first_done = done;
      end
      n_cmp++; if (first_done !== 4'b0100) begin n_err++; $display("FAIL t3_done2: got %b want 0100", first_done); end
      n_cmp++; if (d1 != 0) begin n_err++; $display("FAIL t3_done1_seen: got %0d want 0", d1); end
   endtask

   task automatic test_watchdog();
      int early_err;
      early_err = 0;
      apply_reset();
      tmr_en = 1'b0;
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();                                   // E2: grant
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t4_grant: got %b want 0001", grant); end
      for (int c = 0; c < 16; c++) begin        // E3..E18
         tick();
         if (err !== 1'b0) early_err++;
      end
      n_cmp++; if (early_err != 0) begin n_err++; $display("FAIL t4_err_early: got %0d want 0", early_err); end
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t4_grant_held: got %b want 0001", grant); end
      tick();                                   // E19 = grant + 17
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL t4_err: got %b want 1", err); end
      n_cmp++; if (tmr_clr !== 1'b1) begin n_err++; $display("FAIL t4_tclr: got %b want 1", tmr_clr); end
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t4_grant_rel: got %b want 0000", grant); end
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL t4_nodone: got %b want 0000", done); end
      tick();
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL t4_err_pulse: got %b want 0", err); end
      n_cmp++; if (dut.pend_q !== 4'b0000) begin n_err++; $display("FAIL t4_pend: got %b want 0000", dut.pend_q); end
      tmr_en = 1'b1;
   endtask

   task automatic test_same_cycle();
      // Pulse and cancel together: DONE wins, no timer clear
      apply_reset();
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();                                   // E2
      tick(); tick(); tick(); tick();           // E6
      cancel = 4'b0001;
      tick();                                   // E7
      cancel = 4'b0000;
      n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL t5_done: got %b want 0001", done); end
      n_cmp++; if (tmr_clr !== 1'b0) begin n_err++; $display("FAIL t5_tclr: got %b want 0", tmr_clr); end
      n_cmp++; if (dut.pend_q !== 4'b0000) begin n_err++; $display("FAIL t5_pend_cxl: got %b want 0000", dut.pend_q); end
      // Request together with DONE: pend re-armed, regranted
      apply_reset();
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      tick(); tick(); tick(); tick();           // E6
      req = 4'b0001;
      tick();                                   // E7
      req = 4'b0000;
      n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL t5_done_req: got %b want 0001", done); end
      n_cmp++; if (dut.pend_q !== 4'b0001) begin n_err++; $display("FAIL t5_pend_keep: got %b want 0001", dut.pend_q); end
      tick();
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t5_regrant: got %b want 0001", grant); end
   endtask

   task automatic test_reset_clear();
      int stray;
      stray = 0;
      apply_reset();
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      tick();                                   // mid-wait
      rst_n = 1'b0;
      #1;
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t6_async_grant: got %b want 0000", grant); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_async_busy: got %b want 0", busy); end
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done !== 4'b0000 || err !== 1'b0 || grant !== 4'b0000) stray++;
      end
      n_cmp++; if (stray != 0) begin n_err++; $display("FAIL t6_after_rst: got %0d want 0", stray); end
      // Synchronous clear during wait
      req = 4'b0011;
      tick();
      req = 4'b0000;
      tick();
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t6_grant: got %b want 0001", grant); end
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_cmp++; if (tmr_clr !== 1'b1) begin n_err++; $display("FAIL t6_clr_tclr: got %b want 1", tmr_clr); end
      n_cmp++; if (dut.pend_q !== 4'b0000) begin n_err++; $display("FAIL t6_clr_pend: got %b want 0000", dut.pend_q); end
      n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL t6_clr_idle: got grant %b busy %b want 0000 0", grant, busy); end
      tick();
      n_cmp++; if (tmr_clr !== 1'b0) begin n_err++; $display("FAIL t6_clr_pulse: got %b want 0", tmr_clr); end
      stray = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done !== 4'b0000 || grant !== 4'b0000) stray++;
      end
      n_cmp++; if (stray != 0) begin n_err++; $display("FAIL t6_after_clr: got %0d want 0", stray); end
   endtask

   task automatic test_spurious_pulse();
      apply_reset();
      pulse_inj = 1'b1;
      tick();
      pulse_inj = 1'b0;
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL t7_done: got %b want 0000", done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t7_busy: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_cancel();
      test_watchdog();
      test_same_cycle();
      test_reset_clear();
      test_spurious_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule : tb_timer_scheduler
`default_nettype wire
